// File: rtl/eco32_core_lsu_dcu_pt2.sv
// Per-thread page descriptor table for the LSU data cache way: registered write-first
// lookups, a valid-bit table, and a walker that clears entries on reset or on a flush request.
module eco32_core_lsu_dcu_pt2 #(
    parameter int PAGE_ADDR_WIDTH = 5,
    parameter int THREAD_WIDTH    = 1,
    parameter int DESC_WIDTH      = 39
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_stb,
    input  logic [THREAD_WIDTH-1:0]    i_tid,
    input  logic [PAGE_ADDR_WIDTH-1:0] i_page,
    input  logic                       wr_ena,
    input  logic [THREAD_WIDTH-1:0]    wr_tid,
    input  logic [PAGE_ADDR_WIDTH-1:0] wr_page,
    input  logic [DESC_WIDTH-1:0]      wr_descriptor,
    input  logic                       fl_req,
    input  logic                       fl_all,
    input  logic [THREAD_WIDTH-1:0]    fl_tid,
    output logic                       fl_busy,
    output logic                       fl_ack,
    output logic                       o_stb,
    output logic                       o_valid,
    output logic [DESC_WIDTH-1:0]      o_descriptor
);

    localparam int AW    = PAGE_ADDR_WIDTH + THREAD_WIDTH;
    localparam int N_ALL = 1 << AW;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WALK_T   = 3'd2,
        S_WALK_ALL = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [THREAD_WIDTH-1:0] tid_q, tid_d;

    logic                    clr_en;
    logic [AW-1:0]           clr_addr;

    logic [DESC_WIDTH-1:0]   desc_mem  [N_ALL];
    logic                    valid_mem [N_ALL];

    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;
    logic                    wr_acc;
    logic                    rd_hit;
    logic                    valid_d;
    logic [DESC_WIDTH-1:0]   desc_d;

    logic                    o_stb_q;
    logic                    o_valid_q;
    logic [DESC_WIDTH-1:0]   o_desc_q;

    assign fl_busy = (state_q != S_IDLE);
    assign fl_ack  = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tid_d    = tid_q;
        clr_en   = 1'b0;
        clr_addr = cnt_q;
        case (state_q)
            S_INIT: begin
                clr_en = 1'b1;
                if (cnt_q == '1) state_d = S_IDLE;
                else             cnt_d   = cnt_q + AW'(1);
            end
            S_IDLE: begin
                if (fl_req) begin
                    tid_d   = fl_tid;
                    cnt_d   = '0;
                    state_d = fl_all ? S_WALK_ALL : S_WALK_T;
                end
            end
            S_WALK_T: begin
                clr_en   = 1'b1;
                clr_addr = {cnt_q[PAGE_ADDR_WIDTH-1:0], tid_q};
                // Only the page bits of the counter take part in a per-thread walk.
                if (cnt_q[PAGE_ADDR_WIDTH-1:0] == '1) state_d = S_DONE;
                else                                  cnt_d   = cnt_q + AW'(1);
            end
            S_WALK_ALL: begin
                clr_en = 1'b1;
                if (cnt_q == '1) state_d = S_DONE;
                else             cnt_d   = cnt_q + AW'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
        end
    end

    assign wr_addr = {wr_page, wr_tid};
    assign rd_addr = {i_page, i_tid};
    assign wr_acc  = wr_ena && !fl_busy;

    // Descriptor storage carries no reset; the valid table alone decides what is live.
    always_ff @(posedge clk) begin
        if (wr_acc) desc_mem[wr_addr] <= wr_descriptor;
    end

    always_ff @(posedge clk) begin
        if (clr_en && !rst)  valid_mem[clr_addr] <= 1'b0;
        else if (wr_acc)     valid_mem[wr_addr]  <= 1'b1;
    end

    assign rd_hit  = wr_acc && (wr_addr == rd_addr);
    assign desc_d  = rd_hit ? wr_descriptor : desc_mem[rd_addr];
    assign valid_d = !fl_busy && (rd_hit || valid_mem[rd_addr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_stb_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_desc_q  <= '0;
        end else begin
            o_stb_q <= i_stb;
            if (i_stb) begin
                o_valid_q <= valid_d;
                o_desc_q  <= desc_d;
            end
        end
    end

    assign o_stb        = o_stb_q;
    assign o_valid      = o_valid_q;
    assign o_descriptor = o_desc_q;

endmodule

// File: tb/tb_eco32_core_lsu_dcu_pt2.sv
// Bench for the per-thread page descriptor table: a table-level model checked every cycle,
// plus directed scenarios with hand-derived cycle counts and descriptors.
module tb_eco32_core_lsu_dcu_pt2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stb;
    logic [0:0]  i_tid;
    logic [4:0]  i_page;
    logic        wr_ena;
    logic [0:0]  wr_tid;
    logic [4:0]  wr_page;
    logic [38:0] wr_descriptor;
    logic        fl_req;
    logic        fl_all;
    logic [0:0]  fl_tid;
    logic        fl_busy;
    logic        fl_ack;
    logic        o_stb;
    logic        o_valid;
    logic [38:0] o_descriptor;

    int n_checks = 0;
    int n_err    = 0;

    eco32_core_lsu_dcu_pt2 #(
        .PAGE_ADDR_WIDTH(5),
        .THREAD_WIDTH(1),
        .DESC_WIDTH(39)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_stb(i_stb),
        .i_tid(i_tid),
        .i_page(i_page),
        .wr_ena(wr_ena),
        .wr_tid(wr_tid),
        .wr_page(wr_page),
        .wr_descriptor(wr_descriptor),
        .fl_req(fl_req),
        .fl_all(fl_all),
        .fl_tid(fl_tid),
        .fl_busy(fl_busy),
        .fl_ack(fl_ack),
        .o_stb(o_stb),
        .o_valid(o_valid),
        .o_descriptor(o_descriptor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Table-level model: flushes clear their targets at once, and the busy window is a countdown.
    bit          m_started = 1'b0;
    int          m_busy_left = 0;
    bit          m_ack_pend = 1'b0;
    bit          m_valid [64];
    logic [38:0] m_desc  [64];
    bit          e_stb = 1'b0;
    bit          e_valid = 1'b0;
    bit          e_known = 1'b0;
    logic [38:0] e_desc = '0;

    always @(posedge clk) begin
        int  wa;
        int  ra;
        bit  busy;
        wa = {wr_page, wr_tid};
        ra = {i_page, i_tid};
        if (rst) begin
            m_started   = 1'b1;
            m_busy_left = 64;
            m_ack_pend  = 1'b0;
            e_stb       = 1'b0;
            e_valid     = 1'b0;
            e_desc      = '0;
            e_known     = 1'b1;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else if (m_started) begin
            busy  = (m_busy_left > 0);
            e_stb = i_stb;
            if (i_stb) begin
                if (busy) begin
                    e_valid = 1'b0;
                    e_known = 1'b0;
                end else if (wr_ena && wa == ra) begin
                    e_valid = 1'b1;
                    e_desc  = wr_descriptor;
                    e_known = 1'b1;
                end else begin
                    e_valid = m_valid[ra];
                    e_desc  = m_desc[ra];
                    e_known = m_valid[ra];
                end
            end
            if (busy) begin
                m_busy_left--;
                if (m_busy_left == 0) m_ack_pend = 1'b0;
            end else begin
                if (wr_ena) begin
                    m_desc[wa]  = wr_descriptor;
                    m_valid[wa] = 1'b1;
                end
                if (fl_req) begin
                    for (int i = 0; i < 64; i++)
                        if (fl_all || (i & 1) == int'(fl_tid)) m_valid[i] = 1'b0;
                    m_busy_left = fl_all ? 65 : 33;
                    m_ack_pend  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("fl_busy", 64'(fl_busy), 64'(m_busy_left > 0));
            chk("fl_ack", 64'(fl_ack), 64'(m_ack_pend && m_busy_left == 1));
            chk("o_stb", 64'(o_stb), 64'(e_stb));
            chk("o_valid", 64'(o_valid), 64'(e_valid));
            if (e_known) chk("o_descriptor", 64'(o_descriptor), 64'(e_desc));
        end
    end

    function automatic logic [38:0] fill_val(input int a);
        return 39'h55_0000_0000 + 39'(a) * 39'h0101;
    endfunction

    task automatic do_wr(input int pg, input int t, input logic [38:0] d);
        wr_ena = 1'b1; wr_page = 5'(pg); wr_tid = 1'(t); wr_descriptor = d;
        @(negedge clk);
        wr_ena = 1'b0;
    endtask

    task automatic do_rd(input int pg, input int t);
        i_stb = 1'b1; i_page = 5'(pg); i_tid = 1'(t);
        @(negedge clk);
        i_stb = 1'b0;
    endtask

    task automatic rd_all();
        for (int a = 0; a < 64; a++) begin
            i_stb = 1'b1; i_page = 5'(a >> 1); i_tid = 1'(a & 1);
            @(negedge clk);
        end
        i_stb = 1'b0;
        @(negedge clk);
    endtask

    // Call with rst already high; releases it and measures the INIT busy window.
    task automatic release_and_init(input string tag);
        int n;
        int acks;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        n    = 0;
        acks = 0;
        while (fl_busy && n < 200) begin
            n++;
            if (fl_ack) acks++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd64);
        chk({tag, "_ack_count"}, 64'(acks), 64'd0);
    endtask

    initial begin
        int k;
        int ack_cyc;
        int free_cyc;
        int nack;

        rst = 1'b1; i_stb = 1'b0; i_tid = '0; i_page = '0;
        wr_ena = 1'b0; wr_tid = '0; wr_page = '0; wr_descriptor = '0;
        fl_req = 1'b0; fl_all = 1'b0; fl_tid = '0;

        @(negedge clk);
        chk("reset_busy", 64'(fl_busy), 64'd1);
        chk("reset_ack", 64'(fl_ack), 64'd0);
        chk("reset_stb", 64'(o_stb), 64'd0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_desc", 64'(o_descriptor), 64'd0);
        release_and_init("init");

        do_rd(3, 1);
        chk("lookup_3_1_stb", 64'(o_stb), 64'd1);
        chk("lookup_3_1_valid", 64'(o_valid), 64'd0);

        do_wr(7, 0, 39'h12_3456_789A);
        do_rd(7, 0);
        chk("lookup_7_0_valid", 64'(o_valid), 64'd1);
        chk("lookup_7_0_desc", 64'(o_descriptor), 64'h12_3456_789A);
        do_rd(7, 1);
        chk("lookup_7_1_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        chk("hold_stb_low", 64'(o_stb), 64'd0);

        wr_ena = 1'b1; wr_page = 5'd2; wr_tid = 1'b1; wr_descriptor = 39'h0_0000_00FF;
        i_stb = 1'b1; i_page = 5'd2; i_tid = 1'b1;
        @(negedge clk);
        wr_ena = 1'b0; i_stb = 1'b0;
        chk("bypass_valid", 64'(o_valid), 64'd1);
        chk("bypass_desc", 64'(o_descriptor), 64'hFF);

        for (int a = 0; a < 64; a++) do_wr(a >> 1, a & 1, fill_val(a));
        rd_all();

        // Per-thread flush of tid 1.
        fl_req = 1'b1; fl_all = 1'b0; fl_tid = 1'b1;
        @(negedge clk);
        fl_req = 1'b0;
        k = 1; ack_cyc = -1; free_cyc = -1; nack = 0;
        while (k < 200 && free_cyc < 0) begin
            if (fl_ack) begin nack++; if (ack_cyc < 0) ack_cyc = k; end
            if (!fl_busy) free_cyc = k;
            @(negedge clk);
            k++;
        end
        chk("flush_t_ack_cycle", 64'(ack_cyc), 64'd33);
        chk("flush_t_free_cycle", 64'(free_cyc), 64'd34);
        chk("flush_t_ack_count", 64'(nack), 64'd1);
        rd_all();
        do_rd(5, 0);
        chk("after_flush_t_5_0_valid", 64'(o_valid), 64'd1);
        chk("after_flush_t_5_0_desc", 64'(o_descriptor), 64'h55_0000_0A0A);
        do_rd(5, 1);
        chk("after_flush_t_5_1_valid", 64'(o_valid), 64'd0);

        // Flush-all with a dropped write, a masked lookup and an ignored second request.
        fl_req = 1'b1; fl_all = 1'b1; fl_tid = 1'b0;
        @(negedge clk);
        fl_req = 1'b0;
        k = 1; ack_cyc = -1; free_cyc = -1; nack = 0;
        while (k < 200 && free_cyc < 0) begin
            if (fl_ack) begin nack++; if (ack_cyc < 0) ack_cyc = k; end
            if (!fl_busy) free_cyc = k;
            if (k == 6) chk("walk_lookup_valid", 64'(o_valid), 64'd0);
            wr_ena = (k == 5); wr_page = 5'd9; wr_tid = 1'b0; wr_descriptor = 39'h7F_0000_1111;
            i_stb  = (k == 5); i_page  = 5'd9; i_tid  = 1'b0;
            fl_req = (k == 20);
            @(negedge clk);
            k++;
        end
        wr_ena = 1'b0; i_stb = 1'b0; fl_req = 1'b0;
        chk("flush_all_ack_cycle", 64'(ack_cyc), 64'd65);
        chk("flush_all_free_cycle", 64'(free_cyc), 64'd66);
        chk("flush_all_ack_count", 64'(nack), 64'd1);
        rd_all();
        do_rd(9, 0);
        chk("dropped_write_9_0_valid", 64'(o_valid), 64'd0);

        // Reset in the middle of a per-thread walk.
        do_wr(1, 0, 39'h01_0000_0001);
        do_wr(1, 1, 39'h01_0000_0002);
        do_wr(30, 0, 39'h01_0000_0003);
        fl_req = 1'b1; fl_all = 1'b0; fl_tid = 1'b0;
        @(negedge clk);
        fl_req = 1'b0;
        nack = 0;
        for (int c = 1; c < 10; c++) begin
            if (fl_ack) nack++;
            @(negedge clk);
        end
        rst = 1'b1;
        release_and_init("abort");
        chk("abort_ack_count", 64'(nack), 64'd0);
        rd_all();
        do_rd(1, 1);
        chk("abort_1_1_valid", 64'(o_valid), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/eco32_core_lsu_dcu_pt2.md
# eco32_core_lsu_dcu_pt2

Parametrised per-thread page descriptor table for the data cache way of the load/store unit. It stores one descriptor per (page, thread) pair and supports a variable thread-ID width. Each entry carries a valid bit, and reads are registered with write-first bypass. A flush sequencer clears the valid bits of one thread or of all threads, and the same walk initialises the table after reset.

## Interface
Parameters:
- PAGE_ADDR_WIDTH, 5, page index width
- THREAD_WIDTH, 1, thread ID width
- DESC_WIDTH, 39, descriptor width
- Derived: entries N_ALL = 2^(PAGE_ADDR_WIDTH+THREAD_WIDTH); pages per thread N_PG = 2^PAGE_ADDR_WIDTH

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- i_stb  in  1  lookup request
- i_tid  in  THREAD_WIDTH  lookup thread
- i_page  in  PAGE_ADDR_WIDTH  lookup page
- wr_ena  in  1  descriptor write
- wr_tid  in  THREAD_WIDTH  write thread
- wr_page  in  PAGE_ADDR_WIDTH  write page
- wr_descriptor  in  DESC_WIDTH  write data
- fl_req  in  1  flush request (single-cycle pulse)
- fl_all  in  1  sampled with fl_req; 1 = all threads
- fl_tid  in  THREAD_WIDTH  sampled with fl_req; thread to flush
- fl_busy  out  1  sequencer active; writes ignored
- fl_ack  out  1  one-cycle pulse when a requested flush completes
- o_stb  out  1  lookup result strobe
- o_valid  out  1  looked-up entry is valid
- o_descriptor  out  DESC_WIDTH  looked-up descriptor

## Operation
- Entry address is {page, tid}: page in the MSBs, tid in the LSBs. Descriptor storage is distributed RAM without reset.
- Valid bits live in a separate 1-bit distributed table. They are cleared only by the walk, which clears one entry per cycle.
- Write: when wr_ena=1 and fl_busy=0, the descriptor is written and the entry's valid bit is set at the clock edge. When wr_ena=1 and fl_busy=1, the write is dropped with no effect.
- Lookup: i_stb samples the address.
  - Next cycle: o_stb=1, and o_valid and o_descriptor show the entry.
  - If an accepted write targets the same address in the same cycle, the result shows the written data with o_valid=1 (write-first).
  - While fl_busy=1, o_valid is forced to 0.
- o_descriptor and o_valid hold their last values while i_stb=0.
- Sequencer states:
  - INIT: entered while rst=1, counter=0. After rst falls, it clears entries 0..N_ALL-1, one per cycle. It then goes to IDLE with no fl_ack.
  - IDLE: fl_req=1 latches fl_all and fl_tid and zeroes the counter.
    - fl_all=1: go to WALK_ALL.
    - fl_all=0: go to WALK_T.
  - WALK_T: clears entry {counter, fl_tid} for counter 0..N_PG-1, then goes to DONE.
  - WALK_ALL: clears entry {counter} for counter 0..N_ALL-1, then goes to DONE.
  - DONE: one cycle with fl_ack=1, then IDLE.
- fl_busy=1 in every state except IDLE. fl_req outside IDLE is ignored and produces no ack.
- The counter is PAGE_ADDR_WIDTH+THREAD_WIDTH bits wide. The walk ends on the terminal count; the counter never wraps into a second pass.
- rst mid-walk aborts the walk, returns to INIT with counter 0, and gives no fl_ack for the aborted flush.

## Timing
- Reset values: fl_busy=1, fl_ack=0, o_stb=0, o_valid=0, o_descriptor=0.
- Lookup latency: 1 cycle (i_stb at cycle t gives o_stb at t+1). Back-to-back lookups give one result per cycle.
- Write-to-read: a write at cycle t is visible to a lookup at cycle t (bypass) and to any later lookup.
- Flush with fl_req at cycle 0:
  - WALK_T occupies cycles 1..N_PG. DONE and fl_ack fall in cycle N_PG+1. fl_busy=0 from cycle N_PG+2.
  - WALK_ALL follows the same pattern with N_ALL in place of N_PG.
- INIT after rst falls at cycle 0: clearing runs in cycles 0..N_ALL-1, and fl_busy=0 from cycle N_ALL.

## Test plan
- Reset, then wait: fl_busy stays 1 for exactly 64 cycles after rst falls, with no fl_ack. A lookup of (page 3, tid 1) afterwards gives o_stb=1, o_valid=0.
- Write 0x12_3456_789A to (page 7, tid 0). Lookup (7,0) next cycle -> o_valid=1 with that descriptor. Lookup (7,1) -> o_valid=0.
- Same-cycle write of 0x0_0000_00FF to (2,1) and lookup of (2,1) -> next cycle o_descriptor=0x0_0000_00FF, o_valid=1.
- Fill all 64 entries, then fl_req with fl_all=0, fl_tid=1 at cycle 0:
  - fl_ack pulses at cycle 33 and fl_busy drops at cycle 34.
  - tid 1 entries read invalid; tid 0 entries stay valid with their data intact.
- Start flush-all. A write during the walk is dropped, and a lookup during the walk gives o_valid=0. After fl_ack (cycle 65) all entries read invalid. A second fl_req during the walk gives no extra ack.
- Assert rst at walk cycle 10 of a per-thread flush: no fl_ack. A full 64-cycle INIT walk follows, after which all entries are invalid.
